// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front end for the 2048 game: filters the raw pins, receives
// scan-code frames and turns arrow/WASD keys into a queue of move commands.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data low on a filtered falling edge)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the odd-parity bit
// RX_STOP   | checking stop bit and parity, then reporting byte or error
module ps2_move_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_EN      = 0
) (
    input  logic                          CLK100MHZ,
    input  logic                          RESET,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    input  logic                          move_ready,
    output logic                          move_valid,
    output logic [1:0]                    move_dir,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          restart_req,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_clk_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall;

    rx_state_t     state_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q, rx_byte_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          byte_done_q, frame_err_q;

    logic          ext_q, brk_q, restart_q;
    logic [7:0]    held_q;
    logic          map_hit;
    logic [1:0]    map_dir;
    logic [2:0]    held_idx;
    logic          is_e0, is_f0, push_en, flush;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, pop, full, push_ok;

    // The filtered clock only follows the synchroniser after a full run of
    // FILTER_LEN matching samples, so short spikes never reach the receiver.
    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_s1_q    <= PS2_CLK;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= PS2_DATA;
            dat_s2_q    <= dat_s1_q;
            filt_prev_q <= filt_clk_q;
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_clk_q;

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            state_q     <= RX_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                tmo_q <= TMO_LOAD;
            end else if (tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end
            case (state_q)
                RX_IDLE: begin
                    if (fall && !dat_s2_q) begin
                        state_q   <= RX_DATA;
                        bit_idx_q <= '0;
                    end
                end
                RX_DATA: begin
                    if (fall) begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_q <= RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (fall) begin
                        par_q   <= dat_s2_q;
                        state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (fall) begin
                        if (dat_s2_q && (^{shift_q, par_q})) begin
                            byte_done_q <= 1'b1;
                            rx_byte_q   <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
            if (state_q != RX_IDLE && !fall && tmo_q == '0) begin
                state_q     <= RX_IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        map_hit = 1'b0;
        map_dir = 2'b00;
        if (ext_q) begin
            case (rx_byte_q)
                8'h75: begin map_hit = 1'b1; map_dir = 2'b00; end
                8'h72: begin map_hit = 1'b1; map_dir = 2'b01; end
                8'h6B: begin map_hit = 1'b1; map_dir = 2'b10; end
                8'h74: begin map_hit = 1'b1; map_dir = 2'b11; end
                default: ;
            endcase
        end else begin
            case (rx_byte_q)
                8'h1D: begin map_hit = 1'b1; map_dir = 2'b00; end
                8'h1B: begin map_hit = 1'b1; map_dir = 2'b01; end
                8'h1C: begin map_hit = 1'b1; map_dir = 2'b10; end
                8'h23: begin map_hit = 1'b1; map_dir = 2'b11; end
                default: ;
            endcase
        end
    end

    // Held bits are indexed by {ext, dir}, one per mapped key.
    assign held_idx = {ext_q, map_dir};
    assign is_e0    = rx_byte_q == 8'hE0;
    assign is_f0    = rx_byte_q == 8'hF0;
    assign push_en  = byte_done_q && map_hit && !brk_q &&
                      ((REPEAT_EN != 0) || !held_q[held_idx]);
    assign flush    = byte_done_q && !ext_q && !brk_q && rx_byte_q == 8'h2D;

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            held_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            restart_q <= flush;
            if (frame_err_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_done_q) begin
                if (is_e0) begin
                    ext_q <= 1'b1;
                end else if (is_f0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (map_hit) held_q[held_idx] <= ~brk_q;
                end
            end
        end
    end

    assign full    = count_q == FIFO_FULL;
    assign pop     = (count_q != '0) && move_ready;
    assign push_ok = push_en && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= push_en && full && !pop;
            if (!flush && push_ok) mem_q[wr_ptr_q] <= map_dir;
        end
    end

    assign move_valid  = count_q != '0;
    assign move_dir    = move_valid ? mem_q[rd_ptr_q] : 2'b00;
    assign fifo_count  = count_q;
    assign restart_req = restart_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Scoreboard bench for ps2_move_decoder: a byte-level keyboard model predicts
// the move queue and pulse counts; a monitor checks every pop and pulse.
module tb_ps2_move_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1500;
    localparam int DEPTH      = 4;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst, rst_rep, ps2_clk, ps2_data, move_ready;
    logic       move_valid, restart_req, frame_err, overflow;
    logic [1:0] move_dir;
    logic [2:0] fifo_count;
    logic       rep_valid, rep_restart, rep_ferr, rep_ovf;
    logic [1:0] rep_dir;
    logic [2:0] rep_count;

    always #5 clk = ~clk;

    ps2_move_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT),
                       .FIFO_DEPTH(DEPTH), .REPEAT_EN(0)) dut (
        .CLK100MHZ(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .move_ready(move_ready), .move_valid(move_valid), .move_dir(move_dir),
        .fifo_count(fifo_count), .restart_req(restart_req),
        .frame_err(frame_err), .overflow(overflow));

    ps2_move_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT),
                       .FIFO_DEPTH(DEPTH), .REPEAT_EN(1)) dut_rep (
        .CLK100MHZ(clk), .RESET(rst_rep), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .move_ready(1'b0), .move_valid(rep_valid), .move_dir(rep_dir),
        .fifo_count(rep_count), .restart_req(rep_restart),
        .frame_err(rep_ferr), .overflow(rep_ovf));

    int checks = 0, failures = 0, cyc = 0;
    logic [1:0] exp_q [$];
    int exp_ferr = 0, exp_restart = 0, exp_ovf = 0;
    int seen_ferr = 0, seen_restart = 0, seen_ovf = 0;
    bit m_ext = 0, m_brk = 0, pop_at_push = 0;
    bit m_held [int];
    logic prev_ferr = 0, prev_restart = 0, prev_ovf = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int key_dir(input bit ext, input logic [7:0] b);
        if (ext) begin
            case (b)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_push(input int d);
        if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back(2'(d));
        else exp_ovf++;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        int d, key;
        if (!good) begin
            exp_ferr++;
            m_ext = 0;
            m_brk = 0;
            return;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            d   = key_dir(m_ext, b);
            key = {23'd0, m_ext, b};
            if (d >= 0) begin
                if (m_brk) m_held[key] = 0;
                else begin
                    if (!m_held.exists(key) || !m_held[key]) model_push(d);
                    m_held[key] = 1;
                end
            end else if (!m_ext && !m_brk && b == 8'h2D) begin
                exp_q.delete();
                exp_restart++;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                              input bit bad_stop = 0);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF - 1) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                model_byte(b, !bad_par && !bad_stop);
                if (pop_at_push) begin
                    // DUT push lands 12 edges after this fall: 2 sync + 8 filter + edge + byte_done
                    repeat (11) @(posedge clk);
                    #1 move_ready = 1'b1;
                    @(posedge clk);
                    #1 move_ready = 1'b0;
                    repeat (HALF - 12) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            @(negedge clk);
            ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            repeat (HALF - 1) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic checkpoint(input string tag);
        repeat (4) @(negedge clk);
        check({tag, ":count"}, int'(fifo_count), exp_q.size());
        check({tag, ":valid"}, int'(move_valid), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, ":head"}, int'(move_dir), int'(exp_q[0]));
        check({tag, ":frame_err_pulses"}, seen_ferr, exp_ferr);
        check({tag, ":restart_pulses"}, seen_restart, exp_restart);
        check({tag, ":overflow_pulses"}, seen_ovf, exp_ovf);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
            move_ready = 1'($urandom_range(0, 1));
        end
        move_ready = 1'b0;
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_held.delete();
        m_ext = 0;
        m_brk = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (move_valid && move_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: got dir %0d expected empty queue", move_dir);
                end else if (move_dir !== exp_q[0]) begin
                    failures++;
                    $display("FAIL pop_dir: got %0d expected %0d", move_dir, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (frame_err) begin
                seen_ferr++;
                check("frame_err_width", int'(prev_ferr), 0);
            end
            if (restart_req) begin
                seen_restart++;
                check("restart_width", int'(prev_restart), 0);
                check("restart_flush_count", int'(fifo_count), 0);
            end
            if (overflow) begin
                seen_ovf++;
                check("overflow_width", int'(prev_ovf), 0);
                check("overflow_count", int'(fifo_count), DEPTH);
            end
        end
        prev_ferr    = frame_err;
        prev_restart = restart_req;
        prev_ovf     = overflow;
    end

    always @(posedge clk) begin
        cyc++;
        if (cyc > 95000) begin
            $display("FAIL watchdog: got %0d cycles expected completion", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        logic [7:0] pool [12];
        logic [7:0] b;
        int r, kind;
        bit bad;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h2D, 8'h29};
        rst = 1'b1; rst_rep = 1'b1;
        ps2_clk = 1'b1; ps2_data = 1'b1; move_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst:valid", int'(move_valid), 0);
        check("rst:dir", int'(move_dir), 0);
        check("rst:count", int'(fifo_count), 0);
        check("rst:pulses", int'({restart_req, frame_err, overflow}), 0);
        rst = 1'b0; rst_rep = 1'b0;
        checkpoint("after_reset");

        send_frame(8'hE0); send_frame(8'h75);
        checkpoint("ext_up");
        drain();
        checkpoint("ext_up_drained");

        rst_rep = 1'b1; repeat (3) @(negedge clk); rst_rep = 1'b0;
        repeat (3) send_frame(8'h1C);
        checkpoint("repeat_suppressed");
        check("repeat_en_count", int'(rep_count), 3);
        check("repeat_en_dir", int'(rep_dir), 2);
        send_frame(8'hF0); send_frame(8'h1C); send_frame(8'h1C);
        checkpoint("make_after_break");
        drain();

        send_frame(8'h1D, 1, 0);
        checkpoint("bad_parity");
        send_frame(8'h1D, 0, 1);
        checkpoint("bad_stop");
        send_partial(4);
        exp_ferr++;
        repeat (TIMEOUT + 300) @(negedge clk);
        checkpoint("timeout");
        send_frame(8'h23);
        checkpoint("after_timeout");
        drain();

        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        send_frame(8'hE0); send_frame(8'h75);
        send_frame(8'hE0); send_frame(8'h72);
        send_frame(8'hE0); send_frame(8'h6B);
        send_frame(8'h1D);
        checkpoint("fifo_full");
        send_frame(8'h1B);
        checkpoint("overflow");
        send_frame(8'hE0);
        pop_at_push = 1;
        send_frame(8'h74);
        pop_at_push = 0;
        checkpoint("full_push_pop");
        drain();

        send_frame(8'hF0); send_frame(8'h1D); send_frame(8'hF0); send_frame(8'h1B);
        send_frame(8'h1D); send_frame(8'h1B);
        checkpoint("two_queued");
        send_frame(8'h2D);
        checkpoint("restart");

        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            ps2_data = 1'b0;
            ps2_clk  = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk  = 1'b1;
            repeat (30) @(negedge clk);
        end
        ps2_data = 1'b1;
        checkpoint("glitches");
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
        send_frame(8'hE0); send_frame(8'h6B);
        checkpoint("after_glitches");
        drain();

        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h72);
        send_frame(8'hE0); send_frame(8'h72);
        checkpoint("pre_reset");
        send_partial(4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst:valid", int'(move_valid), 0);
        check("midrst:dir", int'(move_dir), 0);
        check("midrst:count", int'(fifo_count), 0);
        check("midrst:pulses", int'({restart_req, frame_err, overflow}), 0);
        model_reset();
        rst = 1'b0;
        send_frame(8'hE0); send_frame(8'h74);
        checkpoint("post_reset");
        drain();

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 12);
            b = (r < 12) ? pool[r] : 8'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 9) == 0);
            kind = $urandom_range(0, 1);
            send_frame(b, bad && kind == 0, bad && kind == 1);
            if ($urandom_range(0, 3) == 0) checkpoint("random");
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        checkpoint("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
